// File: rtl/fpu_op_arbiter.sv
// Round-robin arbiter that shares one FPU core between two requesters.
// Registers the winner's operands and sequences the beg/ack handshake with a ready timeout.
module fpu_op_arbiter #(
  parameter int W   = 32,
  parameter int TMO = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] X0,
  input  logic [W-1:0] Y0,
  input  logic [W-1:0] X1,
  input  logic [W-1:0] Y1,
  input  logic         op0,
  input  logic         op1,
  input  logic [1:0]   rm0,
  input  logic [1:0]   rm1,
  output logic         done0,
  output logic         done1,
  output logic [W-1:0] result,
  output logic         err,
  output logic         busy,
  output logic         beg_FSM,
  output logic         ack_FSM,
  output logic [W-1:0] Data_X,
  output logic [W-1:0] Data_Y,
  output logic         add_subt,
  output logic [1:0]   r_mode,
  input  logic         ready,
  input  logic [W-1:0] final_result_ieee
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ACK   = 2'd3;

  localparam logic [15:0] TMO_CNT = 16'(TMO);

  logic [1:0]  state;
  logic        last;
  logic        gnt;
  logic [15:0] cnt;

  logic         any_req;
  logic         pick;
  logic [W-1:0] sel_x;
  logic [W-1:0] sel_y;
  logic         sel_op;
  logic [1:0]   sel_rm;

  // On a tie the requester not served last wins; a lone request wins outright.
  always_comb begin
    any_req = req0 | req1;
    pick    = (req0 && req1) ? ~last : req1;
    sel_x   = pick ? X1  : X0;
    sel_y   = pick ? Y1  : Y0;
    sel_op  = pick ? op1 : op0;
    sel_rm  = pick ? rm1 : rm0;
  end

  // NOTE: all state uses non-blocking assignments so every register updates
  // from pre-edge values; reset is synchronous, so it lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 1'b1;
      gnt      <= 1'b0;
      cnt      <= '0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      result   <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      beg_FSM  <= 1'b0;
      ack_FSM  <= 1'b0;
      Data_X   <= '0;
      Data_Y   <= '0;
      add_subt <= 1'b0;
      r_mode   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          // A ready still high from the previous operation blocks a new start.
          if (!ready && any_req) begin
            gnt      <= pick;
            Data_X   <= sel_x;
            Data_Y   <= sel_y;
            add_subt <= sel_op;
            r_mode   <= sel_rm;
            busy     <= 1'b1;
            beg_FSM  <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          beg_FSM <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (ready) begin
            result  <= final_result_ieee;
            err     <= 1'b0;
            ack_FSM <= 1'b1;
            done0   <= ~gnt;
            done1   <= gnt;
            state   <= ACK;
          end else if (cnt == TMO_CNT) begin
            err     <= 1'b1;
            ack_FSM <= 1'b1;
            done0   <= ~gnt;
            done1   <= gnt;
            state   <= ACK;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ACK: begin
          ack_FSM <= 1'b0;
          done0   <= 1'b0;
          done1   <= 1'b0;
          err     <= 1'b0;
          last    <= gnt;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_arbiter.sv
// Directed bench for fpu_op_arbiter with a small behavioural FPU responder.
// Inputs change and outputs are sampled on the falling edge.
module tb_fpu_op_arbiter;

  localparam int W   = 32;
  localparam int TMO = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] X0, Y0, X1, Y1;
  logic         op0, op1;
  logic [1:0]   rm0, rm1;
  logic         done0, done1, err, busy, beg_FSM, ack_FSM, add_subt;
  logic [W-1:0] result, Data_X, Data_Y;
  logic [1:0]   r_mode;
  logic         ready;
  logic [W-1:0] final_result_ieee;

  int vectors     = 0;
  int miscompares = 0;

  int beg_cnt = 0, ack_cnt = 0, done0_cnt = 0, done1_cnt = 0;

  // FPU responder controls
  int          fpu_lat    = 10;
  bit          fpu_never  = 1'b0;
  bit          fpu_sum    = 1'b0;
  logic [31:0] fpu_val    = 32'h0;
  int          stale_hold = 0;

  always #5 clk = ~clk;

  fpu_op_arbiter #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .X0(X0), .Y0(Y0), .X1(X1), .Y1(Y1),
    .op0(op0), .op1(op1), .rm0(rm0), .rm1(rm1),
    .done0(done0), .done1(done1), .result(result), .err(err), .busy(busy),
    .beg_FSM(beg_FSM), .ack_FSM(ack_FSM),
    .Data_X(Data_X), .Data_Y(Data_Y), .add_subt(add_subt), .r_mode(r_mode),
    .ready(ready), .final_result_ieee(final_result_ieee)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (beg_FSM) beg_cnt++;
    if (ack_FSM) ack_cnt++;
    if (done0)   done0_cnt++;
    if (done1)   done1_cnt++;
  end

  // FPU model: ready rises fpu_lat cycles after beg_FSM, drops on ack_FSM
  // (optionally held stale_hold extra cycles), forgets the op if busy drops.
  initial begin
    int phase, cd, hold;
    phase = 0; cd = 0; hold = 0;
    ready = 1'b0;
    final_result_ieee = '0;
    forever begin
      @(negedge clk);
      case (phase)
        0: if (beg_FSM) begin phase = 1; cd = fpu_lat; end
        1: begin
          if (!busy) phase = 0;
          else if (!fpu_never) begin
            cd--;
            if (cd == 0) begin
              final_result_ieee = fpu_sum ? (Data_X + Data_Y) : fpu_val;
              ready = 1'b1;
              phase = 2;
            end
          end
        end
        2: begin
          if (!busy) begin ready = 1'b0; phase = 0; end
          else if (ack_FSM) begin
            if (stale_hold == 0) begin ready = 1'b0; phase = 0; end
            else begin hold = stale_hold; phase = 3; end
          end
        end
        default: begin
          if (hold == 0) begin ready = 1'b0; phase = 0; end
          else hold--;
        end
      endcase
    end
  end

  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done0 || done1) && n < budget);
  endtask

  task automatic wait_beg(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!beg_FSM && n < budget);
  endtask

  // Single uncontended operation by requester g, expected n negedges from beg to done.
  task automatic run_op(input int g, input logic [31:0] exp_res, input int exp_n, input string tag);
    int n;
    if (g == 0) req0 = 1'b1; else req1 = 1'b1;
    @(negedge clk);
    check({tag, " beg"}, beg_FSM, 1'b1);
    check({tag, " data_x"}, Data_X, (g == 0) ? X0 : X1);
    wait_done(exp_n + 5, n);
    check({tag, " latency"}, n, exp_n);
    check({tag, " done0"}, done0, g == 0);
    check({tag, " done1"}, done1, g == 1);
    check({tag, " err"}, err, 1'b0);
    check({tag, " result"}, result, exp_res);
    check({tag, " ack"}, ack_FSM, 1'b1);
    if (g == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    X0 = '0; Y0 = '0; X1 = '0; Y1 = '0;
    op0 = 1'b0; op1 = 1'b0; rm0 = 2'b00; rm1 = 2'b00;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst done0", done0, 1'b0);
    check("rst done1", done1, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst beg", beg_FSM, 1'b0);
    check("rst ack", ack_FSM, 1'b0);
    check("rst err", err, 1'b0);
    check("rst add_subt", add_subt, 1'b0);
    check("rst r_mode", r_mode, 2'b00);
    check("rst data_x", Data_X, 32'h0);
    check("rst data_y", Data_Y, 32'h0);
    check("rst result", result, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single request: 1.0 + 2.0 = 3.0 from the FPU after 10 cycles
    fpu_sum = 1'b0; fpu_val = 32'h4040_0000; fpu_lat = 10;
    X0 = 32'h3F80_0000; Y0 = 32'h4000_0000; op0 = 1'b0; rm0 = 2'b01;
    beg_cnt = 0; done1_cnt = 0;
    req0 = 1'b1;
    @(negedge clk);
    check("single beg", beg_FSM, 1'b1);
    check("single busy", busy, 1'b1);
    check("single data_x", Data_X, 32'h3F80_0000);
    check("single data_y", Data_Y, 32'h4000_0000);
    check("single add_subt", add_subt, 1'b0);
    check("single r_mode", r_mode, 2'b01);
    X0 = 32'h1234_5678;
    wait_done(20, n);
    check("single latency", n, 11);
    check("single done0", done0, 1'b1);
    check("single result", result, 32'h4040_0000);
    check("single err", err, 1'b0);
    check("single ack", ack_FSM, 1'b1);
    check("single operand hold", Data_X, 32'h3F80_0000);
    req0 = 1'b0;
    @(negedge clk);
    check("single idle busy", busy, 1'b0);
    check("single done0 pulse", done0, 1'b0);
    check("single beg count", beg_cnt, 1);
    check("single no done1", done1_cnt, 0);

    // Tie and fairness: both held, expect 0,1,0,1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fpu_sum = 1'b1; fpu_lat = 3;
    X0 = 32'h10;  Y0 = 32'h20;  op0 = 1'b0; rm0 = 2'b00;
    X1 = 32'h100; Y1 = 32'h200; op1 = 1'b1; rm1 = 2'b11;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_beg(10, n);
      check("rr beg", beg_FSM, 1'b1);
      check("rr add_subt", add_subt, (i % 2) == 1);
      check("rr r_mode", r_mode, ((i % 2) == 1) ? 2'b11 : 2'b00);
      wait_done(10, n);
      check("rr latency", n, 4);
      check("rr done0", done0, (i % 2) == 0);
      check("rr done1", done1, (i % 2) == 1);
      check("rr result", result, ((i % 2) == 1) ? 32'h300 : 32'h30);
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    @(negedge clk);

    // Timeout: no ready, request dropped after grant
    fpu_never = 1'b1;
    X0 = 32'hAAAA_0000;
    beg_cnt = 0; ack_cnt = 0; done0_cnt = 0;
    req0 = 1'b1;
    @(negedge clk);
    check("tmo beg", beg_FSM, 1'b1);
    req0 = 1'b0;
    wait_done(TMO + 10, n);
    check("tmo latency", n, TMO + 2);
    check("tmo done0", done0, 1'b1);
    check("tmo err", err, 1'b1);
    check("tmo result kept", result, 32'h300);
    @(negedge clk);
    @(negedge clk);
    check("tmo err pulse", err, 1'b0);
    check("tmo ack count", ack_cnt, 1);
    check("tmo done count", done0_cnt, 1);
    check("tmo busy", busy, 1'b0);
    fpu_never = 1'b0;

    // Ready arrives on the cycle the counter reaches TMO
    fpu_sum = 1'b0; fpu_val = 32'hCAFE_F00D; fpu_lat = TMO + 1;
    run_op(0, 32'hCAFE_F00D, TMO + 2, "race");
    @(negedge clk);

    // Stale ready after ack delays the next grant
    fpu_val = 32'h1111_1111; fpu_lat = 4; stale_hold = 3;
    X1 = 32'h55;
    req0 = 1'b1;
    @(negedge clk);
    check("stale first beg", beg_FSM, 1'b1);
    wait_done(10, n);
    check("stale first done0", done0, 1'b1);
    req0 = 1'b0; req1 = 1'b1;
    wait_beg(10, n);
    check("stale grant delay", n, 5);
    check("stale data_x", Data_X, 32'h55);
    stale_hold = 0; fpu_val = 32'h2222_2222;
    wait_done(10, n);
    check("stale latency", n, 5);
    check("stale done1", done1, 1'b1);
    check("stale result", result, 32'h2222_2222);
    req1 = 1'b0;
    @(negedge clk);

    // Reset mid-operation; last pointer returns to 1 so requester 0 wins the tie
    fpu_val = 32'h3333_3333; fpu_lat = 15;
    X0 = 32'h0A0A_0A0A;
    run_op(0, 32'h3333_3333, 16, "pre");
    @(negedge clk);
    req1 = 1'b1;
    @(negedge clk);
    check("midrst beg", beg_FSM, 1'b1);
    check("midrst data_x", Data_X, 32'h55);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    req0 = 1'b1;
    done0_cnt = 0; done1_cnt = 0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", busy, 1'b0);
    check("midrst beg0", beg_FSM, 1'b0);
    check("midrst ack", ack_FSM, 1'b0);
    check("midrst done0", done0, 1'b0);
    check("midrst done1", done1, 1'b0);
    check("midrst err", err, 1'b0);
    check("midrst data_x0", Data_X, 32'h0);
    check("midrst data_y0", Data_Y, 32'h0);
    check("midrst result", result, 32'h0);
    check("midrst r_mode", r_mode, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    check("regrant beg", beg_FSM, 1'b1);
    check("regrant winner", Data_X, 32'h0A0A_0A0A);
    req1 = 1'b0;
    fpu_val = 32'h4444_4444;
    wait_done(25, n);
    check("regrant latency", n, 16);
    check("regrant done0", done0, 1'b1);
    check("regrant result", result, 32'h4444_4444);
    req0 = 1'b0;
    @(negedge clk);
    check("regrant no done1", done1_cnt, 0);
    check("regrant done0 count", done0_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
